// File: rtl/gmsk_pkg.sv
// Shared definitions for the GMSK-P1 instruction-fetch path.
//   XLEN         : address / instruction width
//   RESET_VECTOR : PC loaded on reset
//   INSTR_BYTES  : bytes per instruction (PC increment)
//   fetch_state_t: fetch sequencer states
package gmsk_pkg;
    localparam int              XLEN         = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam int              INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller, instruction memory, the
// redirect source and decode.
//   master : fetch controller side
//   slave  : environment side (memory / branch unit / decode)
interface fetch_controller_if #(parameter int XLEN = gmsk_pkg::XLEN);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            misalign_err;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, misalign_err,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, misalign_err,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready holding register for the instruction presented
// to decode.
//   clk, rst        : clock, async active-high reset
//   load_i          : capture pc_i/instr_i and raise valid_o
//   pc_i, instr_i   : data to capture
//   flush_i         : drop the held entry (wins over load and consume)
//   ready_i         : decode consumes the entry when valid_o is high
//   valid_o, pc_o, instr_o : registered outputs
module fetch_out_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            flush_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (valid_q && ready_i) begin
            // Data is left in place after consumption; only valid drops.
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one aligned fetch at
// a time, buffers the response for decode, handles redirects and kills
// responses of fetches made stale by a redirect.
//   clk, rst : clock, async active-high reset
//   bus      : fetch_controller_if master (imem request/response,
//              redirect, decode handshake, sticky misalign_err)
module fetch_controller
    import gmsk_pkg::*;
#(
    parameter int              XLEN         = gmsk_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = gmsk_pkg::RESET_VECTOR,
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master bus
);
    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES);

    fetch_state_t    state_q;
    logic [3:0]      boot_cnt_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q;
    logic            misalign_q;

    logic            resp_take;
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc, buf_instr;

    // A response is kept only if it belongs to a live fetch and no
    // redirect lands in the same cycle.
    assign resp_take = (state_q == WAIT) && bus.imem_resp_valid &&
                       !kill_q && !bus.redirect_valid;

    // PC next-value mux: redirect > increment on accepted response > hold.
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid)
            pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
        else if (resp_take)
            pc_d = pc_q + XLEN'(INSTR_BYTES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            boot_cnt_q <= BOOT_INIT;
            pc_q       <= RESET_VECTOR;
            kill_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00))
                misalign_q <= 1'b1;

            case (state_q)
                BOOT: begin
                    if (boot_cnt_q == 4'd0) state_q <= REQ;
                    else                    boot_cnt_q <= boot_cnt_q - 4'd1;
                end
                REQ: begin
                    // A redirect in the accept cycle leaves one stale
                    // fetch in flight; mark it for discard.
                    if (bus.imem_req_ready) begin
                        state_q <= WAIT;
                        if (bus.redirect_valid) kill_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        kill_q  <= 1'b0;
                        state_q <= resp_take ? HOLD : REQ;
                    end else if (bus.redirect_valid) begin
                        kill_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid || bus.if_ready) state_q <= REQ;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    fetch_out_buf #(.XLEN(XLEN)) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (resp_take),
        .pc_i    (pc_q),
        .instr_i (bus.imem_resp_data),
        .flush_i (bus.redirect_valid),
        .ready_i (bus.if_ready),
        .valid_o (buf_valid),
        .pc_o    (buf_pc),
        .instr_o (buf_instr)
    );

    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = buf_valid;
    assign bus.if_pc          = buf_pc;
    assign bus.if_instr       = buf_instr;
    assign bus.misalign_err   = misalign_q;
endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_controller_if #(.XLEN(32)) bus ();

    fetch_controller #(.XLEN(32), .RESET_VECTOR(32'h0), .BOOT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, accept it, return data one cycle later
    // and check the presented instruction.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        while (!bus.imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("req_addr", bus.imem_req_addr, addr);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        chk("wait_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("if_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("if_pc", bus.if_pc, addr);
        chk("if_instr", bus.if_instr, data);
    endtask

    task automatic consume();
        bus.if_ready = 1'b1;
        tick();
        bus.if_ready = 1'b0;
        chk("if_valid_pulse", {31'b0, bus.if_valid}, 32'd0);
        chk("req_after_consume", {31'b0, bus.imem_req_valid}, 32'd1);
    endtask

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.if_ready        = 1'b0;

        // Reset held for 3 edges
        tick(); tick(); tick();
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_misalign", {31'b0, bus.misalign_err}, 32'd0);
        rst = 1'b0;

        // Boot: first request on the 3rd edge after release
        tick(); chk("boot_e1", {31'b0, bus.imem_req_valid}, 32'd0);
        tick(); chk("boot_e2", {31'b0, bus.imem_req_valid}, 32'd0);
        tick(); chk("boot_e3", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("boot_addr", bus.imem_req_addr, 32'h0);

        // Straight-line fetch
        for (int i = 0; i < 4; i++) begin
            do_fetch(32'(i * 4), 32'(32'hA0 + i));
            consume();
        end

        // Back-pressure on fetch at 0x10
        do_fetch(32'h10, 32'hB0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'b0, bus.if_valid}, 32'd1);
            chk("bp_pc", bus.if_pc, 32'h10);
            chk("bp_instr", bus.if_instr, 32'hB0);
            chk("bp_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        end
        consume();
        chk("bp_next_addr", bus.imem_req_addr, 32'h14);

        // Kill in flight: redirect while waiting on 0x14
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("kill_no_present", {31'b0, bus.if_valid}, 32'd0);
        chk("kill_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("kill_addr", bus.imem_req_addr, 32'h100);
        do_fetch(32'h100, 32'h1234);
        consume();

        // Redirect in HOLD with if_ready in the same cycle
        do_fetch(32'h104, 32'h55);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.if_ready       = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b0;
        chk("hold_flush", {31'b0, bus.if_valid}, 32'd0);
        chk("hold_redir_addr", bus.imem_req_addr, 32'h40);
        do_fetch(32'h40, 32'h66);
        consume();

        // Redirect in REQ while not accepted: address switches
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        tick();
        bus.redirect_valid = 1'b0;
        chk("req_redir_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("req_redir_addr", bus.imem_req_addr, 32'h80);

        // Misaligned target + wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        tick();
        bus.redirect_valid = 1'b0;
        chk("misalign_set", {31'b0, bus.misalign_err}, 32'd1);
        chk("misalign_addr", bus.imem_req_addr, 32'hFFFF_FFFC);

        // Stray response outside WAIT is ignored
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h99;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("stray_if_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("stray_addr", bus.imem_req_addr, 32'hFFFF_FFFC);

        do_fetch(32'hFFFF_FFFC, 32'h77);
        consume();
        chk("wrap_addr", bus.imem_req_addr, 32'h0);
        chk("misalign_sticky", {31'b0, bus.misalign_err}, 32'd1);

        // Reset mid-operation (fetch in flight)
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("mid_rst_misalign", {31'b0, bus.misalign_err}, 32'd0);
        chk("mid_rst_addr", bus.imem_req_addr, 32'h0);
        tick();
        rst = 1'b0;
        bus.imem_resp_valid = 1'b1;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("post_rst_resp_ignored", {31'b0, bus.if_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch for the GMSK-P1 core.
- Owns the program counter and issues one word-aligned fetch at a time to instruction memory over a valid/ready request channel.
- Accepts the memory response, holds the result in a one-entry output buffer, and presents it to decode with a valid/ready handshake.
- Handles control-flow redirects (branch/jump), back-pressure from decode, and killing of in-flight fetches.

Parameters:
- XLEN, 32, address and instruction width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- BOOT_CYCLES, 2, idle cycles after reset release before the first request (range 1..15).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (always 4-byte aligned).
- imem_resp_valid  in  1  response data valid; exactly one per accepted request.
- imem_resp_data  in  XLEN  fetched instruction word.
- redirect_valid  in  1  single-cycle pulse: load new PC.
- redirect_pc  in  XLEN  redirect target.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode consumes instruction.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  XLEN  presented instruction word.
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset values (async assert):
  - pc=RESET_VECTOR, state=BOOT, boot counter=BOOT_CYCLES.
  - imem_req_valid=0, imem_req_addr=RESET_VECTOR.
  - if_valid=0, if_pc=0, if_instr=0, misalign_err=0, kill flag=0.
- States:
  - BOOT: counts down. Goes to REQ the cycle after the count reaches 0, so the first imem_req_valid=1 appears BOOT_CYCLES+1 cycles after rst deasserts.
  - REQ: imem_req_valid=1, imem_req_addr=pc. When imem_req_ready=1, the handshake completes; go to WAIT. Address and valid stay stable until accepted.
  - WAIT: imem_req_valid=0. On imem_resp_valid=1:
    - kill flag=1: discard the response, clear the flag, go to REQ.
    - kill flag=0: load if_instr=resp_data, if_pc=pc, if_valid=1, pc<=pc+4, go to HOLD.
  - HOLD: if_valid=1 with if_pc and if_instr stable. When if_ready=1: if_valid<=0 and go to REQ on the next cycle. Prefetch is not supported, so throughput is at most one instruction per 3 cycles with zero-latency memory.
- PC arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no flag.
- Redirect (highest priority, takes effect the cycle redirect_valid=1 is sampled):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - If redirect_pc[1:0] != 0, set misalign_err=1. It stays set until reset.
  - BOOT: latch the PC only; boot countdown continues.
  - REQ, request not accepted that cycle: next request uses the new PC. The old address is withdrawn; memory must tolerate valid dropping with no handshake.
  - REQ, imem_req_ready=1 same cycle: the request is accepted, so set kill=1 and go to WAIT.
  - WAIT: set kill=1. If imem_resp_valid=1 arrives the same cycle, discard that response, clear kill, and go to REQ.
  - HOLD: if_valid<=0 (the instruction is flushed even if if_ready=1 that cycle); go to REQ.
- Simultaneous redirect pulses on consecutive cycles: the last one wins. The kill flag is a single bit and never exceeds one outstanding request.
- Protocol violation: imem_resp_valid outside WAIT is ignored.
- Reset mid-operation: immediate return to reset values. Any outstanding memory response after reset is ignored because the FSM is not in WAIT.

Decomposition:
- Shared package gmsk_pkg:
  - XLEN.
  - RESET_VECTOR.
  - INSTR_BYTES=4.
  - State enum fetch_state_t {BOOT, REQ, WAIT, HOLD}.
- The PC register itself is not a separate sub-module: its next-value mux (hold / +4 / redirect) is embedded in this controller.
- Natural single sub-module: fetch_out_buf (one-entry valid/ready holding register for if_pc/if_instr, with a flush input).

Test Plan:
- Reset + boot: rst high 3 cycles, then low, BOOT_CYCLES=2 → imem_req_valid first high on the 3rd rising edge after release, with addr=0x0000_0000.
- Straight-line fetch: memory ready=1, response 1 cycle later with data 0xA0+n, if_ready=1 → if_pc sequence 0x0, 0x4, 0x8, 0xC with matching if_instr, each if_valid pulse exactly 1 cycle.
- Back-pressure: if_ready=0 for 5 cycles while HOLD → if_valid, if_pc=0x4 and if_instr stable for all 5 cycles, no new imem_req_valid; the next request (addr 0x8) is issued 1 cycle after if_ready=1.
- Kill in flight: redirect_valid with redirect_pc=0x100 while in WAIT for addr 0x8; response 0xDEAD arrives 2 cycles later → 0xDEAD is never presented, next request addr=0x100, if_pc=0x100.
- Redirect in HOLD with if_ready=1 same cycle, target 0x40 → if_valid drops, the instruction is not consumed, next request addr=0x40.
- Misaligned + wrap: redirect_pc=0xFFFF_FFFE → misalign_err=1 (sticky), fetch addr=0xFFFF_FFFC, the following fetch addr=0x0000_0000.
